// File: rtl/lcd_pkg.sv
// Shared constants and types for the character-LCD frame sequencer.
package lcd_pkg;

  localparam int unsigned LCD_COLS  = 16;
  localparam int unsigned LCD_LINES = 2;
  localparam logic [7:0]  LCD_BLANK = 8'h20;

  typedef enum logic [1:0] {
    FUNC_INIT      = 2'd0,
    FUNC_SETCURSOR = 2'd1,
    FUNC_DATA      = 2'd2,
    FUNC_CMD       = 2'd3
  } lcd_func_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_INIT_REQ,
    S_CUR_REQ,
    S_CHR_REQ,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/lcd_frame_buf.sv
// 2x16 character frame buffer: one synchronous write port, one asynchronous read port, reset to blanks.
module lcd_frame_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int unsigned DEPTH = LCD_LINES * LCD_COLS;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= LCD_BLANK;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Replays the frame buffer to the LCD controller as INIT / SETCURSOR / DATA transactions.
// Optional periodic redraw is enabled by defining LCD_SEQ_AUTO_REFRESH_EN.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000,
  parameter logic [31:0] REFRESH_PERIOD = 32'd100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_char,
  input  logic       i_refresh,
  input  logic       i_reinit,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_error,
  output logic [1:0] o_lcd_func,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_req,
  input  logic       i_lcd_done
);

  localparam logic [3:0] LAST_COL = 4'(LCD_COLS - 1);

  seq_state_e state, state_nxt;
  logic       gap, gap_nxt;
  logic       line, line_nxt;
  logic [3:0] col, col_nxt;
  logic       busy, busy_nxt;
  logic       frame_done, frame_done_nxt;
  logic       error, error_nxt;
  logic       req, req_nxt;
  logic [1:0] func, func_nxt;
  logic [7:0] data, data_nxt;
  logic       pending, pending_nxt;
  logic       init_needed, init_nxt;
  logic [31:0] wd;
  logic       refresh_hit;
  logic [7:0] rd_char;
  logic       done_ok, timeout;

  lcd_frame_buf u_buf (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (i_wr_en),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_char),
    .rd_addr ({line, col}),
    .rd_data (rd_char)
  );

  assign done_ok = req & i_lcd_done;
  assign timeout = req & ~i_lcd_done & (wd == TIMEOUT_CYCLES - 32'd1);

`ifdef LCD_SEQ_AUTO_REFRESH_EN
  logic [31:0] refresh_cnt;

  assign refresh_hit = (state == S_IDLE) && (refresh_cnt == REFRESH_PERIOD);

  always_ff @(posedge i_clk) begin
    if (i_rst || frame_done || refresh_hit) refresh_cnt <= '0;
    else if (state == S_IDLE)               refresh_cnt <= refresh_cnt + 32'd1;
  end
`else
  // Period has no effect without the auto-refresh timer.
  assign refresh_hit = 1'b0 & (|REFRESH_PERIOD);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || !req || i_lcd_done || timeout) wd <= '0;
    else                                        wd <= wd + 32'd1;
  end

  always_comb begin
    state_nxt      = state;
    gap_nxt        = gap;
    line_nxt       = line;
    col_nxt        = col;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    error_nxt      = error;
    req_nxt        = req;
    func_nxt       = func;
    data_nxt       = data;
    pending_nxt    = pending | i_refresh | refresh_hit;
    init_nxt       = init_needed;

    case (state)
      S_IDLE: begin
        if (pending || i_refresh || refresh_hit) begin
          state_nxt = S_START;
          busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        pending_nxt = i_refresh;
        error_nxt   = 1'b0;
        req_nxt     = 1'b1;
        gap_nxt     = 1'b0;
        line_nxt    = 1'b0;
        col_nxt     = '0;
        data_nxt    = '0;
        if (init_needed) begin
          state_nxt = S_INIT_REQ;
          func_nxt  = FUNC_INIT;
        end else begin
          state_nxt = S_CUR_REQ;
          func_nxt  = FUNC_SETCURSOR;
        end
      end
      S_INIT_REQ, S_CUR_REQ, S_CHR_REQ: begin
        // The gap cycle loads the next transaction; the request cycles wait for done.
        if (gap) begin
          req_nxt = 1'b1;
          gap_nxt = 1'b0;
          if (state == S_CUR_REQ) begin
            func_nxt = FUNC_SETCURSOR;
            data_nxt = {3'b000, line, 4'h0};
          end else if (state == S_CHR_REQ) begin
            func_nxt = FUNC_DATA;
            data_nxt = rd_char;
          end else begin
            func_nxt = FUNC_INIT;
            data_nxt = '0;
          end
        end else if (done_ok) begin
          req_nxt = 1'b0;
          gap_nxt = 1'b1;
          if (state == S_INIT_REQ) begin
            state_nxt = S_CUR_REQ;
            init_nxt  = 1'b0;
          end else if (state == S_CUR_REQ) begin
            state_nxt = S_CHR_REQ;
            col_nxt   = '0;
          end else if (col != LAST_COL) begin
            col_nxt = col + 4'd1;
          end else if (!line) begin
            state_nxt = S_CUR_REQ;
            line_nxt  = 1'b1;
          end else begin
            state_nxt      = S_DONE;
            gap_nxt        = 1'b0;
            frame_done_nxt = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
          gap_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          error_nxt = 1'b1;
          init_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (i_reinit) init_nxt = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      gap         <= 1'b0;
      line        <= 1'b0;
      col         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      req         <= 1'b0;
      func        <= '0;
      data        <= '0;
      pending     <= 1'b0;
      init_needed <= 1'b1;
    end else begin
      state       <= state_nxt;
      gap         <= gap_nxt;
      line        <= line_nxt;
      col         <= col_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      error       <= error_nxt;
      req         <= req_nxt;
      func        <= func_nxt;
      data        <= data_nxt;
      pending     <= pending_nxt;
      init_needed <= init_nxt;
    end
  end

  assign o_busy       = busy;
  assign o_frame_done = frame_done;
  assign o_error      = error;
  assign o_lcd_func   = func;
  assign o_lcd_data   = data;
  assign o_lcd_req    = req;

endmodule
